// File: rtl/popcount_binarize_pack_pkg.sv
// Shared definitions for the popcount binarize/pack block.
// Contents:
//   POP_CHUNK_BITS - bits covered by one popcount chunk
//   POP_SUM_W      - width of one chunk popcount sum
//   pbp_state_e    - output-side state (accumulating / word held)
//   acc_width()    - accumulator width for a given number of chunks per neuron
package popcount_binarize_pack_pkg;

  localparam int unsigned POP_CHUNK_BITS = 128;
  localparam int unsigned POP_SUM_W      = 8;

  typedef enum logic {
    StIdleAcc,
    StWordHeld
  } pbp_state_e;

  // Wide enough to hold the largest possible dot-product total, 128*chunks.
  function automatic int unsigned acc_width(input int unsigned chunks);
    return $clog2(POP_CHUNK_BITS * chunks + 1);
  endfunction

endpackage

// File: rtl/popcount_binarize_pack_bin_neuron_acc.sv
// Per-neuron accumulator: sums CHUNKS chunk popcounts and compares the total
// against a threshold on the last chunk.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   i_valid      - a chunk sum is accepted this cycle
//   i_flush      - discard any partial neuron accumulation
//   i_sum        - chunk popcount sum
//   i_thr        - neuron threshold (used on the last chunk only)
//   i_inv        - invert the result bit (used on the last chunk only)
//   o_bit        - binarized result for the neuron completing this cycle
//   o_bit_valid  - o_bit is produced this cycle
module popcount_binarize_pack_bin_neuron_acc
  import popcount_binarize_pack_pkg::*;
#(
  parameter int unsigned CHUNKS = 4,
  parameter int unsigned SUM_W  = POP_SUM_W,
  parameter int unsigned ACC_W  = acc_width(CHUNKS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  input  logic             i_flush,
  input  logic [SUM_W-1:0] i_sum,
  input  logic [ACC_W-1:0] i_thr,
  input  logic             i_inv,
  output logic             o_bit,
  output logic             o_bit_valid
);

  localparam int unsigned CNT_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHUNKS - 1);

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_acc_d;
  logic [ACC_W-1:0] w_total;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_d;
  logic             w_last;

  always_comb begin
    w_total     = r_acc + ACC_W'(i_sum);
    w_last      = (r_cnt == LAST_CNT);
    o_bit       = (w_total >= i_thr) ^ i_inv;
    o_bit_valid = i_valid && w_last;

    w_acc_d = r_acc;
    w_cnt_d = r_cnt;
    if (i_valid) begin
      if (w_last) begin
        w_acc_d = '0;
        w_cnt_d = '0;
      end else begin
        w_acc_d = w_total;
        w_cnt_d = r_cnt + 1'b1;
      end
    end
    // A flush drops whatever part of a neuron has been summed so far.
    if (i_flush) begin
      w_acc_d = '0;
      w_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else begin
      r_acc <= w_acc_d;
      r_cnt <= w_cnt_d;
    end
  end

endmodule

// File: rtl/popcount_binarize_pack.sv
// Consumer end of the XNOR-popcount datapath: accumulates chunk sums per neuron,
// binarizes each neuron against its threshold and packs the bits LSB first into
// WORD_W-bit activation words.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_valid / in_ready - input handshake for in_sum/in_thr/in_inv
//   in_sum              - chunk popcount, 0..128
//   in_thr, in_inv      - threshold and invert, sampled on a neuron's last chunk
//   flush               - emit the partially filled word (acts when in_ready=1)
//   out_valid/out_ready - output handshake for out_word/out_nbits
//   out_word            - packed bits, bit 0 = earliest neuron, unused bits 0
//   out_nbits           - number of valid bits in out_word, 1..128
module popcount_binarize_pack
  import popcount_binarize_pack_pkg::*;
#(
  parameter int unsigned CHUNKS = 4,
  parameter int unsigned SUM_W  = POP_SUM_W,
  parameter int unsigned ACC_W  = acc_width(CHUNKS),
  parameter int unsigned WORD_W = POP_CHUNK_BITS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SUM_W-1:0]  in_sum,
  input  logic [ACC_W-1:0]  in_thr,
  input  logic              in_inv,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_word,
  output logic [7:0]        out_nbits
);

  localparam int unsigned CNT_W = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WORD_W);

  pbp_state_e        r_state;
  pbp_state_e        w_state_d;
  logic [WORD_W-1:0] r_pack;
  logic [WORD_W-1:0] w_pack_d;
  logic [WORD_W-1:0] w_pack_ins;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [CNT_W-1:0]  w_bit_cnt_d;
  logic [CNT_W-1:0]  w_bit_cnt_ins;
  logic [WORD_W-1:0] r_out_word;
  logic [WORD_W-1:0] w_out_word_d;
  logic [CNT_W-1:0]  r_out_nbits;
  logic [CNT_W-1:0]  w_out_nbits_d;
  logic              w_accept;
  logic              w_flush;
  logic              w_bit;
  logic              w_bit_valid;
  logic              w_emit;

  assign in_ready  = (r_state == StIdleAcc) || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign w_flush   = flush && in_ready;
  assign out_valid = (r_state == StWordHeld);
  assign out_word  = r_out_word;
  assign out_nbits = 8'(r_out_nbits);

  popcount_binarize_pack_bin_neuron_acc #(
    .CHUNKS (CHUNKS),
    .SUM_W  (SUM_W),
    .ACC_W  (ACC_W)
  ) u_neuron_acc (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_valid     (w_accept),
    .i_flush     (w_flush),
    .i_sum       (in_sum),
    .i_thr       (in_thr),
    .i_inv       (in_inv),
    .o_bit       (w_bit),
    .o_bit_valid (w_bit_valid)
  );

  // Pack contents and count as they stand once this cycle's bit (if any) lands,
  // so a coincident flush or the 128th bit sees the new bit.
  always_comb begin
    w_pack_ins    = r_pack | (WORD_W'(w_bit_valid & w_bit) << r_bit_cnt);
    w_bit_cnt_ins = r_bit_cnt + CNT_W'(w_bit_valid);
    w_emit        = (w_bit_cnt_ins == FULL_CNT) || (w_flush && (w_bit_cnt_ins != '0));
  end

  always_comb begin
    w_state_d     = r_state;
    w_pack_d      = w_pack_ins;
    w_bit_cnt_d   = w_bit_cnt_ins;
    w_out_word_d  = r_out_word;
    w_out_nbits_d = r_out_nbits;

    if (w_emit) begin
      w_out_word_d  = w_pack_ins;
      w_out_nbits_d = w_bit_cnt_ins;
      w_pack_d      = '0;
      w_bit_cnt_d   = '0;
    end

    // An emit in StWordHeld implies out_ready=1, so the held word transfers
    // on the same edge the new one loads.
    unique case (r_state)
      StIdleAcc: begin
        if (w_emit) begin
          w_state_d = StWordHeld;
        end
      end
      StWordHeld: begin
        if (out_ready && !w_emit) begin
          w_state_d = StIdleAcc;
        end
      end
      default: w_state_d = StIdleAcc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdleAcc;
      r_pack      <= '0;
      r_bit_cnt   <= '0;
      r_out_word  <= '0;
      r_out_nbits <= '0;
    end else begin
      r_state     <= w_state_d;
      r_pack      <= w_pack_d;
      r_bit_cnt   <= w_bit_cnt_d;
      r_out_word  <= w_out_word_d;
      r_out_nbits <= w_out_nbits_d;
    end
  end

endmodule

// File: tb/tb_popcount_binarize_pack.sv
// Directed bench for popcount_binarize_pack with hand-computed expectations.
module tb_popcount_binarize_pack;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_sum;
  logic [9:0]   in_thr;
  logic         in_inv;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_word;
  logic [7:0]   out_nbits;

  int n_checks = 0;
  int n_errors = 0;

  popcount_binarize_pack dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .in_thr    (in_thr),
    .in_inv    (in_inv),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_nbits (out_nbits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One input cycle: drive at negedge, wait (bounded) for in_ready, then return
  // #1 after the accepting posedge with inputs dropped.
  task automatic cycle_in(input logic [7:0] s, input logic [9:0] t, input logic inv,
                          input logic v, input logic f);
    int budget;
    budget = 0;
    @(negedge clk);
    in_valid = v;
    in_sum   = s;
    in_thr   = t;
    in_inv   = inv;
    flush    = f;
    while (!in_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready) check("in_ready_timeout", 128'(in_ready), 128'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic neuron(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2,
                        input logic [7:0] s3, input logic [9:0] t, input logic inv,
                        input logic f_last);
    cycle_in(s0, t, inv, 1'b1, 1'b0);
    cycle_in(s1, t, inv, 1'b1, 1'b0);
    cycle_in(s2, t, inv, 1'b1, 1'b0);
    cycle_in(s3, t, inv, 1'b1, f_last);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] alt;
    logic [7:0]   s;
    alt       = {32{4'h5}};
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sum    = '0;
    in_thr    = '0;
    in_inv    = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;

    // Reset state
    #12;
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_in_ready", 128'(in_ready), 128'd1);
    check("rst_out_word", out_word, 128'd0);
    check("rst_out_nbits", 128'(out_nbits), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_out_valid", 128'(out_valid), 128'd0);
    check("idle_in_ready", 128'(in_ready), 128'd1);

    // Bits 1 (256>=256), 0 (256<257), 1 (inverted); flush on the last chunk
    neuron(8'd64, 8'd64, 8'd64, 8'd64, 10'd256, 1'b0, 1'b0);
    neuron(8'd64, 8'd64, 8'd64, 8'd64, 10'd257, 1'b0, 1'b0);
    check("no_early_word", 128'(out_valid), 128'd0);
    neuron(8'd64, 8'd64, 8'd64, 8'd64, 10'd257, 1'b1, 1'b1);
    check("flush3_valid", 128'(out_valid), 128'd1);
    check("flush3_word", out_word, 128'h5);
    check("flush3_nbits", 128'(out_nbits), 128'd3);
    @(posedge clk);
    #1;
    check("flush3_xfer", 128'(out_valid), 128'd0);

    // Flush with nothing pending
    cycle_in(8'd0, 10'd0, 1'b0, 1'b0, 1'b1);
    check("flush_empty", 128'(out_valid), 128'd0);
    @(posedge clk);
    #1;
    check("flush_empty2", 128'(out_valid), 128'd0);

    // 128 neurons alternating 512/0 against 256
    for (int i = 0; i < 127; i++) begin
      s = (i % 2 == 0) ? 8'd128 : 8'd0;
      neuron(s, s, s, s, 10'd256, 1'b0, 1'b0);
    end
    cycle_in(8'd0, 10'd256, 1'b0, 1'b1, 1'b0);
    cycle_in(8'd0, 10'd256, 1'b0, 1'b1, 1'b0);
    cycle_in(8'd0, 10'd256, 1'b0, 1'b1, 1'b0);
    check("full_pre_valid", 128'(out_valid), 128'd0);
    cycle_in(8'd0, 10'd256, 1'b0, 1'b1, 1'b0);
    check("full_valid", 128'(out_valid), 128'd1);
    check("full_word", out_word, alt);
    check("full_nbits", 128'(out_nbits), 128'd128);
    @(posedge clk);
    #1;
    check("full_xfer", 128'(out_valid), 128'd0);

    // Backpressure: word 0x3/2 held, a chunk waits behind it
    neuron(8'd128, 8'd128, 8'd128, 8'd128, 10'd256, 1'b0, 1'b0);
    neuron(8'd128, 8'd128, 8'd128, 8'd128, 10'd256, 1'b0, 1'b0);
    @(negedge clk);
    out_ready = 1'b0;
    cycle_in(8'd0, 10'd0, 1'b0, 1'b0, 1'b1);
    check("bp_valid", 128'(out_valid), 128'd1);
    check("bp_in_ready", 128'(in_ready), 128'd0);
    check("bp_nbits", 128'(out_nbits), 128'd2);
    @(negedge clk);
    in_valid = 1'b1;
    in_sum   = 8'd10;
    in_thr   = 10'd15;
    in_inv   = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold_word", out_word, 128'h3);
      check("bp_hold_ready", 128'(in_ready), 128'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 128'(in_ready), 128'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_xfer", 128'(out_valid), 128'd0);
    // Total 10 < 15 -> bit 0; a duplicated chunk would give 20 -> 1
    cycle_in(8'd0, 10'd15, 1'b0, 1'b1, 1'b0);
    cycle_in(8'd0, 10'd15, 1'b0, 1'b1, 1'b0);
    cycle_in(8'd0, 10'd15, 1'b0, 1'b1, 1'b1);
    check("bp_next_valid", 128'(out_valid), 128'd1);
    check("bp_next_word", out_word, 128'h0);
    check("bp_next_nbits", 128'(out_nbits), 128'd1);

    // Mid-word reset after 5 bits and a partial neuron
    for (int i = 0; i < 5; i++) neuron(8'd64, 8'd64, 8'd64, 8'd64, 10'd256, 1'b0, 1'b0);
    cycle_in(8'd64, 10'd256, 1'b0, 1'b1, 1'b0);
    cycle_in(8'd64, 10'd256, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_valid", 128'(out_valid), 128'd0);
    check("mrst_word", out_word, 128'd0);
    check("mrst_nbits", 128'(out_nbits), 128'd0);
    check("mrst_in_ready", 128'(in_ready), 128'd1);
    @(negedge clk);
    rst_n = 1'b1;
    neuron(8'd64, 8'd64, 8'd64, 8'd64, 10'd256, 1'b0, 1'b1);
    check("mrst_after_valid", 128'(out_valid), 128'd1);
    check("mrst_after_word", out_word, 128'h1);
    check("mrst_after_nbits", 128'(out_nbits), 128'd1);

    // Four bits 1,0,1,1 then a partial neuron, then flush
    neuron(8'd128, 8'd128, 8'd128, 8'd128, 10'd256, 1'b0, 1'b0);
    neuron(8'd0, 8'd0, 8'd0, 8'd0, 10'd256, 1'b0, 1'b0);
    neuron(8'd128, 8'd128, 8'd128, 8'd128, 10'd256, 1'b0, 1'b0);
    neuron(8'd128, 8'd128, 8'd128, 8'd128, 10'd256, 1'b0, 1'b0);
    cycle_in(8'd128, 10'd256, 1'b0, 1'b1, 1'b0);
    cycle_in(8'd128, 10'd256, 1'b0, 1'b1, 1'b0);
    cycle_in(8'd0, 10'd0, 1'b0, 1'b0, 1'b1);
    check("pflush_valid", 128'(out_valid), 128'd1);
    check("pflush_word", out_word, 128'hD);
    check("pflush_nbits", 128'(out_nbits), 128'd4);
    // Fresh neuron total 40 < 41 -> bit 0; leftover partial sum would give 1
    neuron(8'd10, 8'd10, 8'd10, 8'd10, 10'd41, 1'b0, 1'b1);
    check("pflush_next_valid", 128'(out_valid), 128'd1);
    check("pflush_next_word", out_word, 128'h0);
    check("pflush_next_nbits", 128'(out_nbits), 128'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
